// File: rtl/prog_mem.sv
`timescale 1ns / 1ps
// ----------------------------------------------------------------------------
// prog_mem -- writable program memory for the 8-bit CPU
//
// Purpose:
//   Holds DEPTH words of DATA_W bits behind a registered fetch port. After
//   every reset a built-in boot program is copied into the array, one word
//   per clock, while busy is high. A valid/ready load port lets a host or
//   loader overwrite the program while the CPU is held off by busy.
//
// Parameters:
//   ADDR_W  fetch/load address width
//   DATA_W  instruction word width
//   DEPTH   number of words; legal range is 11 .. 2**ADDR_W
//
// Ports:
//   clk         system clock, all logic on the rising edge
//   reset       synchronous, active-high reset
//   fetch_req   fetch strobe from the CPU (only honoured in RUN)
//   address     fetch address
//   dataout     fetched instruction, registered, holds between fetches
//   data_valid  one-cycle pulse: dataout carries a new fetch result
//   busy        high in BOOT or LOAD; the CPU must not fetch
//   load_en     level-sensitive request for load mode
//   load_valid  load word present
//   load_ready  memory accepts load words (high throughout LOAD)
//   load_addr   load word address
//   load_data   load word
//   load_err    sticky: a load targeted an address >= DEPTH
//   inject_par  (PROG_MEM_PARITY_EN only) store inverted parity on loads
//   parity_err  (PROG_MEM_PARITY_EN only) fetch parity mismatch, aligned
//               with data_valid
//
// Configuration macro:
//   PROG_MEM_PARITY_EN  when defined, every word carries an even-parity bit
//                       that is checked on each fetch.
// ----------------------------------------------------------------------------
module prog_mem #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] dataout,
    output logic              data_valid,
    output logic              busy,
    input  logic              load_en,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
`ifdef PROG_MEM_PARITY_EN
    input  logic              inject_par,
    output logic              parity_err,
`endif
    output logic              load_err
);

    // Array index width; addresses are range-checked against DEPTH before
    // their low bits are used as an index.
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef PROG_MEM_PARITY_EN
    localparam int unsigned MEM_W = DATA_W + 1;
`else
    localparam int unsigned MEM_W = DATA_W;
`endif

    localparam logic [IDX_W-1:0] BOOT_LAST = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        StBoot,
        StRun,
        StLoad
    } state_e;

    state_e           state;
    logic [IDX_W-1:0] boot_cnt;

    // ------------------------------------------------------------------------
    // Boot image: words 0..10 are the resident program, the rest are zero.
    // ------------------------------------------------------------------------
    function automatic logic [DATA_W-1:0] boot_word(input logic [IDX_W-1:0] idx);
        logic [7:0] w;
        w = 8'h00;
        case (32'(idx))
            0:       w = 8'h05;
            1:       w = 8'h81;
            2:       w = 8'h0A;
            3:       w = 8'h82;
            4:       w = 8'h44;
            5:       w = 8'h99;
            6:       w = 8'h0F;
            7:       w = 8'h82;
            8:       w = 8'h45;
            9:       w = 8'h00;
            10:      w = 8'hC1;
            default: w = 8'h00;
        endcase
        return DATA_W'(w);
    endfunction

    // ------------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------------
    logic fetch_in_range;
    logic load_in_range;
    logic load_fire;

    assign fetch_in_range = 32'(address) < DEPTH;
    assign load_in_range  = 32'(load_addr) < DEPTH;

    // A word is only taken while load_en is still high, so a word offered in
    // the exit cycle is refused even though load_ready is still asserted.
    assign load_fire = (state == StLoad) && load_en && load_valid && load_ready;

    // ------------------------------------------------------------------------
    // Write port: BOOT copies the image, LOAD writes accepted in-range words.
    // Nothing is written in a reset cycle.
    // ------------------------------------------------------------------------
    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_winj;
    logic [MEM_W-1:0]  mem_wword;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = boot_cnt;
        mem_wdata = boot_word(boot_cnt);
        mem_winj  = 1'b0;
        if (!reset) begin
            if (state == StBoot) begin
                mem_we = 1'b1;
            end else if (load_fire && load_in_range) begin
                mem_we    = 1'b1;
                mem_waddr = load_addr[IDX_W-1:0];
                mem_wdata = load_data;
`ifdef PROG_MEM_PARITY_EN
                mem_winj  = inject_par;
`endif
            end
        end
    end

`ifdef PROG_MEM_PARITY_EN
    // Even parity: the stored bit makes the XOR of the whole word zero.
    // inject_par flips it so the next fetch of that word reports an error.
    assign mem_wword = {(^mem_wdata) ^ mem_winj, mem_wdata};
`else
    assign mem_wword = mem_wdata;
    logic unused_winj;
    assign unused_winj = mem_winj;
`endif

    // ------------------------------------------------------------------------
    // Storage: single-port array, synchronous write, read registered below.
    // ------------------------------------------------------------------------
    logic [MEM_W-1:0] mem [DEPTH];
    logic [MEM_W-1:0] rd_word;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wword;
        end
    end

    assign rd_word = mem[address[IDX_W-1:0]];

    // ------------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StBoot;
            boot_cnt   <= '0;
            dataout    <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b1;
            load_ready <= 1'b0;
            load_err   <= 1'b0;
`ifdef PROG_MEM_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            data_valid <= 1'b0;
`ifdef PROG_MEM_PARITY_EN
            parity_err <= 1'b0;
`endif
            unique case (state)
                StBoot: begin
                    // Fetch and load inputs are ignored until the image is in.
                    if (boot_cnt == BOOT_LAST) begin
                        state <= StRun;
                        busy  <= 1'b0;
                    end else begin
                        boot_cnt <= boot_cnt + IDX_W'(1);
                    end
                end

                StRun: begin
                    if (fetch_req) begin
                        data_valid <= 1'b1;
                        dataout    <= fetch_in_range ? rd_word[DATA_W-1:0] : '0;
`ifdef PROG_MEM_PARITY_EN
                        parity_err <= fetch_in_range && (^rd_word);
`endif
                    end
                    // A fetch in the cycle load_en rises is still served above.
                    if (load_en) begin
                        state      <= StLoad;
                        busy       <= 1'b1;
                        load_ready <= 1'b1;
                    end
                end

                StLoad: begin
                    if (load_fire && !load_in_range) begin
                        load_err <= 1'b1;
                    end
                    if (!load_en) begin
                        state      <= StRun;
                        busy       <= 1'b0;
                        load_ready <= 1'b0;
                    end
                end

                default: begin
                    state <= StBoot;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_mem.sv
`timescale 1ns / 1ps
// Bench for prog_mem: a 256-word and a 16-word instance share all inputs and
// are each checked against an array model built from the boot image table
// and the load/fetch rules.
module tb_prog_mem;

    localparam int BIG   = 256;
    localparam int SMALL = 16;
    localparam logic [7:0] IMG [11] = '{8'h05, 8'h81, 8'h0A, 8'h82, 8'h44, 8'h99,
                                        8'h0F, 8'h82, 8'h45, 8'h00, 8'hC1};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       fetch_req = 1'b0;
    logic [7:0] address = '0;
    logic       load_en = 1'b0;
    logic       load_valid = 1'b0;
    logic [7:0] load_addr = '0;
    logic [7:0] load_data = '0;

    logic [7:0] b_dataout, s_dataout;
    logic       b_data_valid, s_data_valid, b_busy, s_busy;
    logic       b_load_ready, s_load_ready, b_load_err, s_load_err;
`ifdef PROG_MEM_PARITY_EN
    logic       inject_par = 1'b0;
    logic       b_parity_err, s_parity_err;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model
    logic [7:0] m_big   [BIG];
    logic [7:0] m_small [SMALL];
    logic       e_big, e_small;

    always #5 clk = ~clk;

    prog_mem #(.ADDR_W(8), .DATA_W(8), .DEPTH(BIG)) dut_big (
        .clk        (clk),
        .reset      (reset),
        .fetch_req  (fetch_req),
        .address    (address),
        .dataout    (b_dataout),
        .data_valid (b_data_valid),
        .busy       (b_busy),
        .load_en    (load_en),
        .load_valid (load_valid),
        .load_ready (b_load_ready),
        .load_addr  (load_addr),
        .load_data  (load_data),
`ifdef PROG_MEM_PARITY_EN
        .inject_par (inject_par),
        .parity_err (b_parity_err),
`endif
        .load_err   (b_load_err)
    );

    prog_mem #(.ADDR_W(8), .DATA_W(8), .DEPTH(SMALL)) dut_small (
        .clk        (clk),
        .reset      (reset),
        .fetch_req  (fetch_req),
        .address    (address),
        .dataout    (s_dataout),
        .data_valid (s_data_valid),
        .busy       (s_busy),
        .load_en    (load_en),
        .load_valid (load_valid),
        .load_ready (s_load_ready),
        .load_addr  (load_addr),
        .load_data  (load_data),
`ifdef PROG_MEM_PARITY_EN
        .inject_par (inject_par),
        .parity_err (s_parity_err),
`endif
        .load_err   (s_load_err)
    );

    // ---------------- model ----------------
    function automatic logic [7:0] boot_img(input int i);
        return (i < 11) ? IMG[i] : 8'h00;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < BIG; i++) m_big[i] = boot_img(i);
        for (int i = 0; i < SMALL; i++) m_small[i] = boot_img(i);
        e_big = 1'b0;
        e_small = 1'b0;
    endtask

    task automatic model_load(input int a, input logic [7:0] d);
        if (a < BIG) m_big[a] = d; else e_big = 1'b1;
        if (a < SMALL) m_small[a] = d; else e_small = 1'b1;
    endtask

    function automatic logic [7:0] exp_big(input int a);
        return m_big[a];
    endfunction

    function automatic logic [7:0] exp_small(input int a);
        return (a < SMALL) ? m_small[a] : 8'h00;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns the cycle count after reset release at which busy first reads low.
    task automatic wait_boot(output int nb, output int ns);
        nb = -1;
        ns = -1;
        for (int c = 1; c <= 400; c++) begin
            step();
            if (ns < 0 && !s_busy) ns = c;
            if (!b_busy) begin
                nb = c;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int nb, ns, bad;
        reset = 1'b1;
        step();
        step();
        checks++; if (b_busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b want 1", b_busy); end
        checks++; if (b_data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", b_data_valid); end
        checks++; if (b_dataout !== 8'h00) begin errors++; $display("FAIL reset_dataout got %h want 00", b_dataout); end
        checks++; if (b_load_ready !== 1'b0 || s_load_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b/%b want 0/0", b_load_ready, s_load_ready); end
        checks++; if (b_load_err !== 1'b0 || s_load_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b/%b want 0/0", b_load_err, s_load_err); end
        model_reset();
        // Fetch and load requests during BOOT must be ignored.
        reset = 1'b0;
        fetch_req = 1'b1; address = 8'd1;
        load_en = 1'b1; load_valid = 1'b1; load_addr = 8'd0; load_data = 8'hAA;
        nb = -1; ns = -1; bad = 0;
        for (int c = 1; c <= 400; c++) begin
            step();
            if (c <= 10 && (b_data_valid || s_data_valid || b_load_ready || s_load_ready)) bad++;
            if (c == 10) begin
                fetch_req = 1'b0; load_en = 1'b0; load_valid = 1'b0;
            end
            if (ns < 0 && !s_busy) ns = c;
            if (!b_busy) begin
                nb = c;
                break;
            end
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL boot_ignores_inputs got %0d responses want 0", bad); end
        checks++; if (nb !== BIG) begin errors++; $display("FAIL boot_len_big got %0d want %0d", nb, BIG); end
        checks++; if (ns !== SMALL) begin errors++; $display("FAIL boot_len_small got %0d want %0d", ns, SMALL); end
    endtask

    task automatic test_fetch_boot();
        int addrs [5] = '{0, 1, 4, 10, 11};
        foreach (addrs[i]) begin
            fetch_req = 1'b1;
            address = 8'(addrs[i]);
            step();
            fetch_req = 1'b0;
            address = 8'($urandom_range(0, 255));
            checks++; if (b_data_valid !== 1'b1 || b_dataout !== exp_big(addrs[i])) begin
                errors++; $display("FAIL fetch_big a=%0d got v=%b d=%h want v=1 d=%h", addrs[i], b_data_valid, b_dataout, exp_big(addrs[i])); end
            checks++; if (s_data_valid !== 1'b1 || s_dataout !== exp_small(addrs[i])) begin
                errors++; $display("FAIL fetch_small a=%0d got v=%b d=%h want v=1 d=%h", addrs[i], s_data_valid, s_dataout, exp_small(addrs[i])); end
            step();
            checks++; if (b_data_valid !== 1'b0 || b_dataout !== exp_big(addrs[i])) begin
                errors++; $display("FAIL fetch_hold a=%0d got v=%b d=%h want v=0 d=%h", addrs[i], b_data_valid, b_dataout, exp_big(addrs[i])); end
        end
    endtask

    task automatic test_back_to_back();
        int addrs [3] = '{2, 3, 5};
        fetch_req = 1'b1;
        foreach (addrs[i]) begin
            address = 8'(addrs[i]);
            step();
            checks++; if (b_data_valid !== 1'b1 || b_dataout !== exp_big(addrs[i])) begin
                errors++; $display("FAIL b2b_big a=%0d got v=%b d=%h want v=1 d=%h", addrs[i], b_data_valid, b_dataout, exp_big(addrs[i])); end
            checks++; if (s_data_valid !== 1'b1 || s_dataout !== exp_small(addrs[i])) begin
                errors++; $display("FAIL b2b_small a=%0d got v=%b d=%h want v=1 d=%h", addrs[i], s_data_valid, s_dataout, exp_small(addrs[i])); end
        end
        fetch_req = 1'b0;
        step();
        checks++; if (b_data_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_valid got %b want 0", b_data_valid); end
    endtask

    task automatic test_load_err();
        load_en = 1'b1;
        step();
        checks++; if (s_load_ready !== 1'b1 || s_busy !== 1'b1) begin errors++; $display("FAIL lerr_enter got r=%b b=%b want 1/1", s_load_ready, s_busy); end
        checks++; if (s_load_err !== 1'b0) begin errors++; $display("FAIL lerr_before got %b want 0", s_load_err); end
        load_valid = 1'b1; load_addr = 8'd20; load_data = 8'h5A;
        step();
        model_load(20, 8'h5A);
        load_valid = 1'b0;
        checks++; if (s_load_err !== e_small || b_load_err !== e_big) begin
            errors++; $display("FAIL lerr_set got s=%b b=%b want s=%b b=%b", s_load_err, b_load_err, e_small, e_big); end
        load_en = 1'b0;
        step();
        checks++; if (s_load_ready !== 1'b0 || s_busy !== 1'b0 || s_load_err !== 1'b1) begin
            errors++; $display("FAIL lerr_exit got r=%b b=%b e=%b want 0/0/1", s_load_ready, s_busy, s_load_err); end
        fetch_req = 1'b1; address = 8'd20;
        step();
        fetch_req = 1'b0;
        checks++; if (s_data_valid !== 1'b1 || s_dataout !== exp_small(20)) begin
            errors++; $display("FAIL lerr_fetch_small got v=%b d=%h want v=1 d=%h", s_data_valid, s_dataout, exp_small(20)); end
        checks++; if (b_dataout !== exp_big(20)) begin errors++; $display("FAIL lerr_fetch_big got %h want %h", b_dataout, exp_big(20)); end
    endtask

    task automatic test_load();
        int addrs [3] = '{4, 200, 5};
        // Fetch in the same cycle load_en rises is served.
        load_en = 1'b1; fetch_req = 1'b1; address = 8'd1;
        step();
        address = 8'd2;
        checks++; if (b_data_valid !== 1'b1 || b_dataout !== exp_big(1)) begin
            errors++; $display("FAIL load_entry_fetch got v=%b d=%h want v=1 d=%h", b_data_valid, b_dataout, exp_big(1)); end
        checks++; if (b_load_ready !== 1'b1 || b_busy !== 1'b1) begin errors++; $display("FAIL load_ready got r=%b b=%b want 1/1", b_load_ready, b_busy); end
        // Fetch during LOAD is ignored.
        step();
        fetch_req = 1'b0;
        checks++; if (b_data_valid !== 1'b0 || b_dataout !== exp_big(1)) begin
            errors++; $display("FAIL load_fetch_ignored got v=%b d=%h want v=0 d=%h", b_data_valid, b_dataout, exp_big(1)); end
        load_valid = 1'b1; load_addr = 8'd4; load_data = 8'h3C;
        step(); model_load(4, 8'h3C);
        load_addr = 8'd200; load_data = 8'h7E;
        step(); model_load(200, 8'h7E);
        // Word offered in the exit cycle must not be written.
        load_en = 1'b0; load_addr = 8'd5; load_data = 8'h55;
        step();
        load_valid = 1'b0;
        checks++; if (b_load_ready !== 1'b0 || b_busy !== 1'b0) begin errors++; $display("FAIL load_exit got r=%b b=%b want 0/0", b_load_ready, b_busy); end
        fetch_req = 1'b1;
        foreach (addrs[i]) begin
            address = 8'(addrs[i]);
            step();
            checks++; if (b_data_valid !== 1'b1 || b_dataout !== exp_big(addrs[i])) begin
                errors++; $display("FAIL load_fetch_big a=%0d got v=%b d=%h want v=1 d=%h", addrs[i], b_data_valid, b_dataout, exp_big(addrs[i])); end
            checks++; if (s_dataout !== exp_small(addrs[i])) begin
                errors++; $display("FAIL load_fetch_small a=%0d got %h want %h", addrs[i], s_dataout, exp_small(addrs[i])); end
        end
        fetch_req = 1'b0;
        checks++; if (b_load_err !== 1'b0 || s_load_err !== e_small) begin
            errors++; $display("FAIL load_err_flags got b=%b s=%b want 0/%b", b_load_err, s_load_err, e_small); end
    endtask

    task automatic test_random();
        logic [7:0] last_b, last_s;
        bit have_last;
        int a;
        for (int r = 0; r < 30; r++) begin
            load_en = 1'b1;
            step();
            for (int k = 0; k < int'($urandom_range(1, 6)); k++) begin
                load_valid = 1'($urandom_range(0, 1));
                load_addr = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 23)) : 8'($urandom_range(0, 255));
                load_data = 8'($urandom_range(0, 255));
                step();
                if (load_valid) model_load(int'(load_addr), load_data);
                checks++; if (s_load_err !== e_small || b_load_err !== e_big) begin
                    errors++; $display("FAIL rnd_err r=%0d got s=%b b=%b want s=%b b=%b", r, s_load_err, b_load_err, e_small, e_big); end
            end
            load_valid = 1'b0; load_en = 1'b0;
            step();
            have_last = 1'b0;
            last_b = '0;
            last_s = '0;
            for (int k = 0; k < int'($urandom_range(1, 6)); k++) begin
                fetch_req = ($urandom_range(0, 3) != 0);
                address = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 23)) : 8'($urandom_range(0, 255));
                a = int'(address);
                step();
                if (fetch_req) begin
                    last_b = exp_big(a);
                    last_s = exp_small(a);
                    have_last = 1'b1;
                    checks++; if (b_data_valid !== 1'b1 || b_dataout !== last_b || s_data_valid !== 1'b1 || s_dataout !== last_s) begin
                        errors++; $display("FAIL rnd_fetch a=%0d got b=%b/%h s=%b/%h want 1/%h 1/%h", a, b_data_valid, b_dataout, s_data_valid, s_dataout, last_b, last_s); end
                end else begin
                    checks++; if (b_data_valid !== 1'b0 || s_data_valid !== 1'b0 || (have_last && (b_dataout !== last_b || s_dataout !== last_s))) begin
                        errors++; $display("FAIL rnd_idle got b=%b/%h s=%b/%h want 0/%h 0/%h", b_data_valid, b_dataout, s_data_valid, s_dataout, last_b, last_s); end
                end
            end
            fetch_req = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        int nb, ns;
        load_en = 1'b1;
        step();
        load_valid = 1'b1; load_addr = 8'd0; load_data = 8'hFF;
        step(); model_load(0, 8'hFF);
        load_addr = 8'd1; load_data = 8'hEE;
        reset = 1'b1;
        step();
        reset = 1'b0; load_en = 1'b0; load_valid = 1'b0;
        model_reset();
        checks++; if (b_busy !== 1'b1 || b_load_ready !== 1'b0 || s_load_err !== 1'b0) begin
            errors++; $display("FAIL midload_reset got b=%b r=%b e=%b want 1/0/0", b_busy, b_load_ready, s_load_err); end
        // Interrupt the boot itself; the full image must still be rewritten.
        for (int c = 0; c < 40; c++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        wait_boot(nb, ns);
        checks++; if (nb !== BIG || ns !== SMALL) begin errors++; $display("FAIL midboot_len got %0d/%0d want %0d/%0d", nb, ns, BIG, SMALL); end
        fetch_req = 1'b1;
        for (int a = 0; a < 3; a++) begin
            address = 8'(a);
            step();
            checks++; if (b_data_valid !== 1'b1 || b_dataout !== exp_big(a) || s_dataout !== exp_small(a)) begin
                errors++; $display("FAIL reboot_fetch a=%0d got v=%b b=%h s=%h want 1 %h %h", a, b_data_valid, b_dataout, s_dataout, exp_big(a), exp_small(a)); end
        end
        fetch_req = 1'b0;
        step();
    endtask

`ifdef PROG_MEM_PARITY_EN
    task automatic test_parity();
        load_en = 1'b1;
        step();
        inject_par = 1'b1; load_valid = 1'b1; load_addr = 8'd7; load_data = 8'h12;
        step(); model_load(7, 8'h12);
        inject_par = 1'b0; load_addr = 8'd6; load_data = 8'h34;
        step(); model_load(6, 8'h34);
        load_valid = 1'b0; load_en = 1'b0;
        step();
        fetch_req = 1'b1; address = 8'd7;
        step();
        checks++; if (b_parity_err !== 1'b1 || b_data_valid !== 1'b1 || s_parity_err !== 1'b1 || b_dataout !== exp_big(7)) begin
            errors++; $display("FAIL parity_inject got pe=%b/%b v=%b d=%h want 1/1 1 %h", b_parity_err, s_parity_err, b_data_valid, b_dataout, exp_big(7)); end
        address = 8'd6;
        step();
        fetch_req = 1'b0;
        checks++; if (b_parity_err !== 1'b0 || s_parity_err !== 1'b0) begin
            errors++; $display("FAIL parity_clean got %b/%b want 0/0", b_parity_err, s_parity_err); end
        step();
        checks++; if (b_parity_err !== 1'b0) begin errors++; $display("FAIL parity_pulse got %b want 0", b_parity_err); end
    endtask
`endif

    initial begin
        test_reset();
        test_fetch_boot();
        test_back_to_back();
        test_load_err();
        test_load();
        test_random();
        test_reset_mid();
`ifdef PROG_MEM_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/prog_mem.md
Name: prog_mem

Overview:
Parametrised, writable program memory for the 8-bit CPU, replacing the fixed combinational instruction ROM. It holds DEPTH words of DATA_W bits with a registered fetch port. A built-in boot program is copied into the array after every reset. A valid/ready load port lets a host or loader overwrite the program while the CPU is held off.

Parameters:
ADDR_W, 8, fetch/load address width
DATA_W, 8, instruction word width
DEPTH, 256, number of words; must be >= 11 and <= 2**ADDR_W

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
fetch_req  in  1  fetch strobe from CPU
address  in  ADDR_W  fetch address
dataout  out  DATA_W  fetched instruction, registered
data_valid  out  1  one-cycle pulse: dataout holds a new fetch result
busy  out  1  high in BOOT or LOAD; CPU must not fetch
load_en  in  1  request load mode; level-sensitive
load_valid  in  1  load word present
load_ready  out  1  memory accepts load word
load_addr  in  ADDR_W  load word address
load_data  in  DATA_W  load word
load_err  out  1  sticky: a load targeted address >= DEPTH

Behaviour:
- One clock domain (clk); reset is synchronous and active-high.
- Reset values: dataout=0, data_valid=0, busy=1, load_ready=0, load_err=0, state=BOOT, boot counter=0.
- States: BOOT, RUN, LOAD.
- BOOT:
  - Writes one word per cycle at counter address, for counter = 0..DEPTH-1.
  - Boot image: 0:0x05, 1:0x81, 2:0x0A, 3:0x82, 4:0x44, 5:0x99, 6:0x0F, 7:0x82, 8:0x45, 9:0x00, 10:0xC1; all other words 0x00.
  - After the DEPTH-1 write, goes to RUN. BOOT lasts exactly DEPTH cycles; busy drops on the first RUN cycle.
  - fetch_req and load inputs are ignored during BOOT.
- RUN:
  - fetch_req=1 at edge N gives dataout=mem[address] and data_valid=1 after edge N+1 (1-cycle latency).
  - data_valid stays low when fetch_req=0. dataout holds its last value between fetches.
  - Back-to-back fetch_req gives one result per cycle.
  - address >= DEPTH: dataout=0x00 with data_valid=1.
  - load_en=1: next state LOAD. A fetch_req in the same cycle is still served normally.
- LOAD:
  - busy=1 and load_ready=1. fetch_req is ignored: no data_valid, dataout unchanged.
  - load_valid & load_ready at an edge: if load_addr < DEPTH, mem[load_addr] <= load_data; otherwise the write is dropped and load_err is set.
  - load_en=0: next state RUN; load_ready drops the same edge. A word presented in that exit cycle is not accepted.
  - Written data is visible to a fetch issued on the first RUN cycle.
- load_err clears only on reset.
- Reset mid-BOOT or mid-LOAD: returns to BOOT and rewrites the whole boot image. Partially loaded programs are lost; no write occurs in the reset cycle.
- Memory inference: a single-port array, written from BOOT or LOAD only. The fetch read is a synchronous read.

Optional Feature:
PROG_MEM_PARITY_EN:
- When defined: each word stores an extra even-parity bit, computed on every write (boot or load).
- Each fetch recomputes parity. A mismatch raises output parity_err (1 bit) for one cycle, aligned with data_valid. parity_err resets to 0.
- Test hook input inject_par (1 bit): when high during a load write, it stores the inverted parity bit.
- When undefined: parity_err and inject_par are absent and no parity storage is generated.

Test Plan:
- Reset, then wait DEPTH cycles -> busy=1 throughout BOOT and falls at cycle DEPTH. Fetch addresses 0,1,4,10,11 -> dataout 0x05,0x81,0x44,0xC1,0x00, each one cycle after its request, data_valid pulsed.
- Back-to-back fetches of addresses 2,3,5 on consecutive cycles -> data_valid high 3 consecutive cycles with 0x0A,0x82,0x99.
- load_en=1, write 0x3C@4 and 0x7E@200 (DEPTH=256), drop load_en, fetch 4 and 200 -> 0x3C and 0x7E; load_err stays 0.
- DEPTH=16: load to address 20 -> write dropped and load_err=1, persisting after return to RUN. A following fetch of address 20 -> 0x00.
- fetch_req during LOAD -> no data_valid, dataout unchanged. fetch_req in the same cycle load_en rises -> served one cycle later.
- Mid-LOAD after overwriting address 0 with 0xFF, assert reset -> BOOT repeats, and a fetch of address 0 returns 0x05. With PROG_MEM_PARITY_EN defined, a load with inject_par=1 then a fetch of that address -> parity_err=1 with data_valid.
